// File: rtl/convolver_pkg.sv
// rtl/convolver_pkg.sv - shared state encodings for the convolver datapath blocks
package convolver_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer, highest element first
module piso_serializer
    import convolver_pkg::*;
#(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [SIZE*DATA_WIDTH-1:0] load_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] COUNT_TOP = CW'(SIZE - 1);

    ser_state_t                 state, state_next;
    logic [SIZE*DATA_WIDTH-1:0] word, word_next;
    logic [CW-1:0]              count, count_next;
    logic [DATA_WIDTH-1:0]      data_next;
    logic                       valid_next, last_next;
    logic                       load_fire, out_fire;

    // Ready in the last-handshake cycle lets the next word follow without a bubble.
    assign load_ready = (state == ST_IDLE) || (out_valid && out_ready && out_last);
    assign load_fire  = load_valid && load_ready;
    assign out_fire   = out_valid && out_ready;
    assign busy       = (state == ST_SHIFT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            word      <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_next;
            word      <= word_next;
            count     <= count_next;
            out_data  <= data_next;
            out_valid <= valid_next;
            out_last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        word_next  = word;
        count_next = count;
        data_next  = out_data;
        valid_next = out_valid;
        last_next  = out_last;

        case (state)
            ST_IDLE: begin
                if (load_fire) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (load_fire) state_next = ST_SHIFT;
                else if (out_fire && out_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (load_fire) begin
            word_next  = load_data;
            count_next = COUNT_TOP;
            data_next  = load_data[SIZE*DATA_WIDTH-1 -: DATA_WIDTH];
            valid_next = 1'b1;
            last_next  = (SIZE == 1);
        end else if (out_fire) begin
            if (out_last) begin
                count_next = '0;
                data_next  = '0;
                valid_next = 1'b0;
                last_next  = 1'b0;
            end else begin
                count_next = count - 1'b1;
                data_next  = word[DATA_WIDTH*int'(count_next) +: DATA_WIDTH];
                last_next  = (count_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (SIZE=3, DATA_WIDTH=8)
module tb_piso_serializer;

    localparam int SIZE = 3;
    localparam int DW   = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [SIZE*DW-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t             sb[$];
    exp_t             exp_e;
    logic [SIZE*DW-1:0] sr;
    int               total = 0;
    int               bad   = 0;

    piso_serializer #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Sample handshakes at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clock);
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL sb_underflow observed=%0h expected=none", out_data);
                end else begin
                    exp_e = sb.pop_front();
                    chk("sb_data", 32'(out_data), 32'(exp_e.data));
                    chk("sb_last", 32'(out_last), 32'(exp_e.last));
                    sr = {sr[(SIZE-1)*DW-1:0], out_data};
                end
            end
            if (!out_valid) chk("idle_data_zero", 32'(out_data), 32'h0);
            if (load_valid && load_ready) begin
                for (int k = SIZE - 1; k >= 0; k--) begin
                    exp_t e;
                    e.data = load_data[DW*k +: DW];
                    e.last = (k == 0);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && busy; i++) tick();
        chk({tag, "_idle"}, 32'(busy), 32'h0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        logic [DW-1:0] b2b_exp [6];
        b2b_exp = '{8'h03, 8'h02, 8'h01, 8'h06, 8'h05, 8'h04};

        reset = 1'b1; load_data = '0; load_valid = 1'b0; out_ready = 1'b0; sr = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_load_ready", 32'(load_ready), 32'h1);

        // Basic word, downstream always ready; shift-register model rebuilds the word.
        out_ready = 1'b1; load_data = 24'h030201; load_valid = 1'b1; sr = '0;
        tick();
        load_valid = 1'b0;
        chk("basic_c1_data", 32'(out_data), 32'h03);
        chk("basic_c1_valid", 32'(out_valid), 32'h1);
        chk("basic_c1_last", 32'(out_last), 32'h0);
        chk("basic_c1_busy", 32'(busy), 32'h1);
        chk("basic_c1_ready", 32'(load_ready), 32'h0);
        tick();
        chk("basic_c2_data", 32'(out_data), 32'h02);
        chk("basic_c2_last", 32'(out_last), 32'h0);
        tick();
        chk("basic_c3_data", 32'(out_data), 32'h01);
        chk("basic_c3_last", 32'(out_last), 32'h1);
        chk("basic_c3_ready", 32'(load_ready), 32'h1);
        tick();
        chk("shift_reg_word", 32'(sr), 32'h030201);
        chk("basic_end_valid", 32'(out_valid), 32'h0);
        chk("basic_end_busy", 32'(busy), 32'h0);

        // Backpressure: element 0x02 must hold while out_ready is low.
        load_data = 24'h030201; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_data", 32'(out_data), 32'h02);
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_last", 32'(out_last), 32'h0);
        end
        out_ready = 1'b1;
        drain("stall");

        // Back-to-back words with load_valid held: six contiguous elements.
        load_data = 24'h030201; load_valid = 1'b1;
        tick();
        load_data = 24'h060504;
        for (int i = 0; i < 6; i++) begin
            chk("b2b_valid", 32'(out_valid), 32'h1);
            chk("b2b_data", 32'(out_data), 32'(b2b_exp[i]));
            tick();
            if (i == 2) load_valid = 1'b0;
        end
        chk("b2b_end_valid", 32'(out_valid), 32'h0);
        drain("b2b");

        // Load attempt while busy mid-word is ignored.
        load_data = 24'h0D0E0F; load_valid = 1'b1;
        tick();
        load_data = 24'h777777;
        tick();
        load_valid = 1'b0;
        chk("ignore_data", 32'(out_data), 32'h0E);
        chk("ignore_ready", 32'(load_ready), 32'h0);
        drain("ignore");

        // Reset mid-word beats a simultaneous load and output handshake.
        load_data = 24'h030201; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        reset = 1'b1; load_data = 24'h555555; load_valid = 1'b1;
        tick();
        reset = 1'b0; load_valid = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", 32'(out_data), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(load_ready), 32'h1);
        load_data = 24'h0A0B0C; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("postrst_first", 32'(out_data), 32'h0A);
        drain("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter SIZE, default 3, number of elements per parallel word (SIZE >= 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per element.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_data  input  SIZE*DATA_WIDTH  packed parallel word; element k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
REQ-006 SHALL have port load_valid  input  1  load_data is valid.
REQ-007 SHALL have port load_ready  output  1  block can accept a parallel word this cycle.
REQ-008 SHALL have port out_data  output  DATA_WIDTH  current serial element.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port out_last  output  1  out_data is the final element of the word.
REQ-012 SHALL have port busy  output  1  a word is held or being emitted.

Function
REQ-013 SHALL accept a load when load_valid && load_ready at a rising edge, capturing all SIZE elements into internal registers.
REQ-014 SHALL emit elements in order SIZE-1, SIZE-2, ..., 0, so that feeding the stream into the team's shift register for SIZE shifts reproduces load_data at its parallel output.
REQ-015 SHALL implement FSM IDLE -> SHIFT on an accepted load; SHIFT -> IDLE when the out_last element is accepted and no new load is accepted that cycle; SHIFT -> SHIFT on an accepted load in the same cycle.
REQ-016 SHALL assert out_valid, and present element SIZE-1 on out_data, in the cycle after the load is accepted (latency 1); all outputs are registered.
REQ-017 SHALL advance one element per cycle only when out_valid && out_ready; out_data, out_valid and out_last SHALL hold stable while out_valid && !out_ready.
REQ-018 SHALL assert out_last exactly with element 0; for SIZE=1 every element is last.
REQ-019 SHALL drive load_ready = 1 in IDLE, and in SHIFT only when out_valid && out_ready && out_last (back-to-back words, no bubble).
REQ-020 SHALL ignore load_valid while load_ready = 0; the held word is not modified.
REQ-021 SHALL use an element counter of width max(1, clog2(SIZE)) counting SIZE-1 down to 0; no wrap beyond 0.
REQ-022 SHALL drive busy = 1 in SHIFT, 0 in IDLE; out_data SHALL be 0 whenever out_valid = 0.

Reset
REQ-023 SHALL, on reset high at a rising edge, set FSM to IDLE, counter to 0, internal registers to 0, out_data = 0, out_valid = 0, out_last = 0, busy = 0, load_ready = 1.
REQ-024 SHALL, on reset mid-word, discard remaining elements; first post-reset load behaves as from IDLE.
REQ-025 SHALL give reset priority over a simultaneous load or output handshake.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE, SHIFT) in the shared convolver package; SIZE/DATA_WIDTH stay module parameters.
REQ-027 SHALL be a single module; no sub-module is required.

Verification
REQ-028 SIZE=3, DATA_WIDTH=8, load 0x030201, out_ready=1 -> out_data 0x03,0x02,0x01 on cycles 1-3; out_last only with 0x01; load_ready=1 on cycle 3.
REQ-029 Same load, out_ready low cycles 2-3 -> out_data holds 0x02 with out_valid=1 until out_ready returns; no element lost or repeated.
REQ-030 Back-to-back loads 0x030201 then 0x060504, load_valid held, out_ready=1 -> six contiguous valid cycles 03,02,01,06,05,04 with no bubble.
REQ-031 Reset asserted after 0x03 emitted -> next cycle out_valid=0, out_data=0, busy=0, load_ready=1; new load 0x0A0B0C emits 0x0A first.
REQ-032 load_valid with new data while busy and not on last handshake -> ignored; original word completes unchanged.
REQ-033 Serializer output into shift register (SIZE=3) -> shift register parallel output equals 0x030201 after the third accepted element.
